// File: rtl/lcd_bus_scheduler_if.sv
// Requester handshakes plus the LCD pins owned by lcd_bus_scheduler.
// The scheduler takes the slave side; requesters and the bench take the master side.
interface lcd_bus_scheduler_if;
    logic       cmd_valid_i;
    logic [7:0] cmd_data_i;
    logic       cmd_ready_o;
    logic       chr_valid_i;
    logic [7:0] chr_data_i;
    logic       chr_ready_o;
    logic       init_done_o;
    logic       busy_o;
    logic [7:0] lcd_data_o;
    logic       lcd_rs_o;
    logic       lcd_enable_o;

    modport slave (
        input  cmd_valid_i, cmd_data_i, chr_valid_i, chr_data_i,
        output cmd_ready_o, chr_ready_o, init_done_o, busy_o,
               lcd_data_o, lcd_rs_o, lcd_enable_o
    );

    modport master (
        output cmd_valid_i, cmd_data_i, chr_valid_i, chr_data_i,
        input  cmd_ready_o, chr_ready_o, init_done_o, busy_o,
               lcd_data_o, lcd_rs_o, lcd_enable_o
    );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// Single owner of the HD44780 8-bit bus: power-up init, then round-robin between
// command and character requesters, one timed E pulse plus execution wait per byte.
module lcd_bus_scheduler #(
    parameter int POWERUP_CYCLES   = 750000,
    parameter int SETUP_CYCLES     = 2,
    parameter int PULSE_CYCLES     = 12,
    parameter int HOLD_CYCLES      = 2,
    parameter int EXEC_CYCLES      = 2500,
    parameter int LONG_EXEC_CYCLES = 90000
) (
    input  logic               fpga_clk_i,
    input  logic               fpga_reset_ni,
    lcd_bus_scheduler_if.slave bus
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(POWERUP_CYCLES, SETUP_CYCLES),
                                       max2(PULSE_CYCLES, HOLD_CYCLES)),
                                  max2(EXEC_CYCLES, LONG_EXEC_CYCLES));
    localparam int CNT_W = max2($clog2(MAX_CYC + 1), 20);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] LEXEC_LD = CNT_W'(LONG_EXEC_CYCLES - 1);
    localparam logic [2:0]       LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_IDLE
    } state_e;

    function automatic logic [7:0] init_rom(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h06;
            default:          return 8'h01;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic             done_q, done_d;
    logic             last_chr_q, last_chr_d;

    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;
    logic             long_exec;
    logic             accept_ok;
    logic             cmd_rdy, chr_rdy;
    logic             cmd_fire, chr_fire;

    assign cnt_zero  = (cnt_q == '0);
    assign cnt_dec   = cnt_q - CNT_W'(1);
    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign long_exec = !rs_q && (data_q[7:2] == 6'd0);

    // A port whose peer is idle is always ready; under contention the one not
    // granted last time wins.
    assign accept_ok = (state_q == S_IDLE) && done_q;
    assign cmd_rdy   = accept_ok && (!bus.chr_valid_i || (bus.cmd_valid_i && last_chr_q));
    assign chr_rdy   = accept_ok && (!bus.cmd_valid_i || (bus.chr_valid_i && !last_chr_q));
    assign cmd_fire  = cmd_rdy && bus.cmd_valid_i;
    assign chr_fire  = chr_rdy && bus.chr_valid_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        rs_d       = rs_q;
        done_d     = done_q;
        last_chr_d = last_chr_q;
        case (state_q)
            S_PWRUP: begin
                if (cnt_zero) state_d = S_INIT;
                else          cnt_d   = cnt_dec;
            end
            S_INIT: begin
                data_d  = init_rom(idx_q);
                rs_d    = 1'b0;
                cnt_d   = SETUP_LD;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    cnt_d   = PULSE_LD;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    cnt_d   = long_exec ? LEXEC_LD : EXEC_LD;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_EXEC: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_dec;
                end else if (done_q) begin
                    state_d = S_IDLE;
                end else if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_INIT;
                end
            end
            S_IDLE: begin
                if (cmd_fire) begin
                    data_d     = bus.cmd_data_i;
                    rs_d       = 1'b0;
                    last_chr_d = 1'b0;
                    cnt_d      = SETUP_LD;
                    state_d    = S_SETUP;
                end else if (chr_fire) begin
                    data_d     = bus.chr_data_i;
                    rs_d       = 1'b1;
                    last_chr_d = 1'b1;
                    cnt_d      = SETUP_LD;
                    state_d    = S_SETUP;
                end
            end
            default: begin
                cnt_d   = PWR_LD;
                state_d = S_PWRUP;
            end
        endcase
    end

    // E is registered so the pin is glitch-free; it tracks entry into PULSE.
    assign e_d = (state_d == S_PULSE);

    always_ff @(posedge fpga_clk_i or negedge fpga_reset_ni) begin
        if (!fpga_reset_ni) begin
            state_q    <= S_PWRUP;
            cnt_q      <= PWR_LD;
            idx_q      <= '0;
            data_q     <= '0;
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            done_q     <= 1'b0;
            last_chr_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            rs_q       <= rs_d;
            e_q        <= e_d;
            done_q     <= done_d;
            last_chr_q <= last_chr_d;
        end
    end

    assign bus.cmd_ready_o  = cmd_rdy;
    assign bus.chr_ready_o  = chr_rdy;
    assign bus.init_done_o  = done_q;
    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.lcd_data_o   = data_q;
    assign bus.lcd_rs_o     = rs_q;
    assign bus.lcd_enable_o = e_q;
endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: transaction-timeline reference model checked every
// cycle, directed timing checks with literal expectations, and random traffic.
module tb_lcd_bus_scheduler;
    localparam int PW = 20, S = 1, P = 2, H = 1, X = 3, LX = 8;
    localparam logic [7:0] ROM [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lcd_bus_scheduler_if bus_if();

    lcd_bus_scheduler #(
        .POWERUP_CYCLES(PW), .SETUP_CYCLES(S), .PULSE_CYCLES(P),
        .HOLD_CYCLES(H), .EXEC_CYCLES(X), .LONG_EXEC_CYCLES(LX)
    ) dut (
        .fpga_clk_i   (clk),
        .fpga_reset_ni(rst_n),
        .bus          (bus_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each byte is a transaction accepted at cycle t; all pin
    // behaviour follows from t by arithmetic on the phase lengths.
    int         k, t_cur, idle_at, init_idx;
    bit         done, last_chr;
    logic [7:0] bus_d, pend_d;
    logic       bus_rs, pend_rs;
    logic       e_x, idle_x, cr_x, hr_x, cv, hv;

    // Observations of the DUT for the directed checks.
    int         hs_cnt = 0, last_hs_k = -1;
    bit         hs_log[$];
    int         init_rises, first_rise_k, last_rise_k, last_fall_k, done_k, ready_back_k;
    logic       e_prev, rdy_prev, pulse_rs;
    logic [7:0] pulse_d;

    function automatic int exec_len(input logic [7:0] d, input logic rs);
        return (!rs && d <= 8'h03) ? LX : X;
    endfunction

    task automatic start(input int t, input logic [7:0] d, input logic rs);
        t_cur   = t;
        pend_d  = d;
        pend_rs = rs;
        idle_at = t + 1 + S + P + H + exec_len(d, rs);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_enable", 32'(bus_if.lcd_enable_o), 32'd0);
            chk("rst_busy",   32'(bus_if.busy_o),       32'd1);
            chk("rst_ready",  32'({bus_if.cmd_ready_o, bus_if.chr_ready_o}), 32'd0);
            chk("rst_bus",    32'({bus_if.lcd_rs_o, bus_if.lcd_data_o, bus_if.init_done_o}), 32'd0);
            k = 0; t_cur = -1; idle_at = -1; init_idx = 0;
            done = 0; last_chr = 1; bus_d = '0; bus_rs = 1'b0;
            init_rises = 0; first_rise_k = -1; last_rise_k = -1; last_fall_k = -1;
            done_k = -1; ready_back_k = -1; e_prev = 1'b0; rdy_prev = 1'b0;
        end else begin
            if (t_cur >= 0 && k == t_cur + 1) begin
                bus_d  = pend_d;
                bus_rs = pend_rs;
            end
            if (k == PW) begin
                start(k, ROM[0], 1'b0);
            end else if (!done && t_cur >= 0 && k == idle_at) begin
                if (init_idx < 5) begin
                    init_idx++;
                    start(k, ROM[init_idx], 1'b0);
                end else begin
                    done = 1;
                end
            end
            idle_x = done && k >= idle_at;
            e_x    = t_cur >= 0 && k >= t_cur + 1 + S && k <= t_cur + S + P;
            cv = bus_if.cmd_valid_i;
            hv = bus_if.chr_valid_i;
            cr_x = 1'b0;
            hr_x = 1'b0;
            if (idle_x) begin
                if (cv && hv)  begin cr_x = last_chr; hr_x = !last_chr; end
                else if (cv)   cr_x = 1'b1;
                else if (hv)   hr_x = 1'b1;
                else           begin cr_x = 1'b1; hr_x = 1'b1; end
            end
            chk("enable",    32'(bus_if.lcd_enable_o), 32'(e_x));
            chk("lcd_data",  32'(bus_if.lcd_data_o),   32'(bus_d));
            chk("lcd_rs",    32'(bus_if.lcd_rs_o),     32'(bus_rs));
            chk("busy",      32'(bus_if.busy_o),       32'(!idle_x));
            chk("init_done", 32'(bus_if.init_done_o),  32'(done));
            chk("cmd_ready", 32'(bus_if.cmd_ready_o),  32'(cr_x));
            chk("chr_ready", 32'(bus_if.chr_ready_o),  32'(hr_x));

            if (bus_if.lcd_enable_o && !e_prev) begin
                last_rise_k = k;
                pulse_rs    = bus_if.lcd_rs_o;
                pulse_d     = bus_if.lcd_data_o;
                if (!bus_if.init_done_o) begin
                    if (init_rises == 0) first_rise_k = k;
                    init_rises++;
                end
            end
            if (!bus_if.lcd_enable_o && e_prev) last_fall_k = k;
            if (bus_if.init_done_o && done_k < 0) done_k = k;
            if ((bus_if.cmd_ready_o || bus_if.chr_ready_o) && !rdy_prev) ready_back_k = k;
            e_prev   = bus_if.lcd_enable_o;
            rdy_prev = bus_if.cmd_ready_o || bus_if.chr_ready_o;

            if (cv && cr_x) begin
                start(k, bus_if.cmd_data_i, 1'b0);
                last_chr = 0;
                hs_log.push_back(1'b0);
                hs_cnt++;
                last_hs_k = k;
            end else if (hv && hr_x) begin
                start(k, bus_if.chr_data_i, 1'b1);
                last_chr = 1;
                hs_log.push_back(1'b1);
                hs_cnt++;
                last_hs_k = k;
            end
            k++;
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!bus_if.init_done_o && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("init_timeout", 32'(n >= 500), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus_if.busy_o && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("idle_timeout", 32'(n >= 300), 32'd0);
    endtask

    // Offer one byte on one port, drop valid after acceptance, wait for ready to return.
    task automatic send(input bit is_chr, input logic [7:0] d, output int acc, output int back);
        int n = 0;
        int c0 = hs_cnt;
        if (is_chr) begin bus_if.chr_valid_i = 1'b1; bus_if.chr_data_i = d; end
        else        begin bus_if.cmd_valid_i = 1'b1; bus_if.cmd_data_i = d; end
        while (hs_cnt == c0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus_if.cmd_valid_i = 1'b0;
        bus_if.chr_valid_i = 1'b0;
        chk("accept_timeout", 32'(n >= 300), 32'd0);
        acc = last_hs_k;
        n = 0;
        while (ready_back_k <= acc && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("ready_timeout", 32'(n >= 300), 32'd0);
        back = ready_back_k;
    endtask

    initial begin
        int acc, back, n, c0;
        bus_if.cmd_valid_i = 1'b0; bus_if.cmd_data_i = '0;
        bus_if.chr_valid_i = 1'b0; bus_if.chr_data_i = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Power-up: init entry 0 at cycle 20 pulses at 22; entries every 8 cycles,
        // the last one (0x01) waits 8, so init completes at 60+13 = 73.
        wait_done();
        chk("init_first_rise", 32'(first_rise_k), 32'd22);
        chk("init_pulses",     32'(init_rises),   32'd6);
        chk("init_done_cycle", 32'(done_k),       32'd73);

        send(1'b1, 8'h48, acc, back);
        chk("chr_rise_delay", 32'(last_rise_k - acc), 32'd2);
        chk("chr_pulse_width", 32'(last_fall_k - last_rise_k), 32'd2);
        chk("chr_ready_back", 32'(back - acc), 32'd8);
        chk("chr_pulse_rs",   32'(pulse_rs), 32'd1);
        chk("chr_pulse_data", 32'(pulse_d),  32'h48);

        // Both held valid: last grant was CHR, so CMD,CHR,CMD,CHR.
        c0 = hs_cnt;
        n = 0;
        bus_if.cmd_data_i = 8'h80; bus_if.chr_data_i = 8'h41;
        bus_if.cmd_valid_i = 1'b1; bus_if.chr_valid_i = 1'b1;
        while (hs_cnt < c0 + 4 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus_if.cmd_valid_i = 1'b0; bus_if.chr_valid_i = 1'b0;
        chk("rr_timeout", 32'(n >= 400), 32'd0);
        if (n < 400) begin
            for (int i = 0; i < 4; i++) chk("rr_grant", 32'(hs_log[c0 + i]), 32'(i % 2));
        end
        wait_idle();

        send(1'b0, 8'h01, acc, back);
        chk("clear_ready_back", 32'(back - acc), 32'd13);
        chk("clear_pulse_rs", 32'(pulse_rs), 32'd0);
        send(1'b0, 8'h80, acc, back);
        chk("cursor_ready_back", 32'(back - acc), 32'd8);
        chk("cursor_pulse_data", 32'(pulse_d), 32'h80);

        // Random traffic, including valids that are dropped before being accepted.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            bus_if.cmd_valid_i = ($urandom_range(0, 3) != 0);
            bus_if.chr_valid_i = ($urandom_range(0, 2) != 0);
            bus_if.cmd_data_i  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                              : 8'($urandom);
            bus_if.chr_data_i  = 8'($urandom);
        end
        @(posedge clk);
        #1;
        bus_if.cmd_valid_i = 1'b0; bus_if.chr_valid_i = 1'b0;
        wait_idle();

        // Reset in the middle of an E pulse, then full init replay with both valids held.
        bus_if.cmd_valid_i = 1'b1; bus_if.cmd_data_i = 8'h80;
        n = 0;
        while (!bus_if.lcd_enable_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pulse_timeout", 32'(n >= 50), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_enable", 32'(bus_if.lcd_enable_o), 32'd0);
        bus_if.chr_valid_i = 1'b1; bus_if.chr_data_i = 8'h41;
        bus_if.cmd_data_i  = 8'h01;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done();
        chk("replay_first_rise", 32'(first_rise_k), 32'd22);
        chk("replay_pulses",     32'(init_rises),   32'd6);
        chk("replay_done_cycle", 32'(done_k),       32'd73);
        bus_if.cmd_valid_i = 1'b0; bus_if.chr_valid_i = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 reached");
        $fatal(1, "watchdog");
    end
endmodule
